// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiplier issue stage:
// FSM state encoding, default operand width and word-select constants.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Operand/result handshake bundle plus the multiplier operand/product wires.
// slave = the issue stage, master = whoever feeds it and owns the multiplier.
interface mul_issue_ctrl_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_hi;
  logic                 flush;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_overflow;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_b, in_hi, flush, mul_product, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_result, out_overflow, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_hi, flush, mul_product, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_result, out_overflow, busy
  );
endinterface

// File: rtl/mul_issue_ctrl_settle_timer.sv
// Loadable 4-bit down-counter that measures the multiplier settle window.
// Stops at zero so `zero` stays asserted until the next load.
module mul_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);
  logic [3:0] r_count;

  // Load on accept, otherwise count down while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/result stage around an external combinational signed multiplier.
// Operands are held on mul_a/mul_b for SETTLE_CYCLES, then the product is
// captured, the requested word selected and signed overflow flagged.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH         = MUL_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  mul_issue_ctrl_if.slave bus
);
  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  mul_state_e         r_state;
  mul_state_e         w_next_state;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_hi;
  logic [WIDTH-1:0]   r_result;
  logic               r_overflow;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_capture;
  logic               w_zero;
  logic [WIDTH:0]     w_top_bits;

  // Ready depends only on state and out_ready; flush blocks the accept itself.
  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_capture  = (r_state == ST_BUSY) && w_zero && !bus.flush;

  // Product fits in WIDTH signed bits only when its top WIDTH+1 bits agree.
  assign w_top_bits = bus.mul_product[2*WIDTH-1:WIDTH-1];

  mul_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_accept),
    .load_val (LOAD_VAL),
    .en       (r_state == ST_BUSY),
    .zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves it unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
      ST_BUSY: if (w_zero)   w_next_state = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next_state = w_accept ? ST_BUSY : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (bus.flush) w_next_state = ST_IDLE;
  end

  // Operand hold registers and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_hi       <= SEL_LO;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mul_a <= bus.in_a;
        r_mul_b <= bus.in_b;
        r_hi    <= bus.in_hi;
      end
      if (w_capture) begin
        r_result   <= (r_hi == SEL_HI) ? bus.mul_product[2*WIDTH-1:WIDTH]
                                       : bus.mul_product[WIDTH-1:0];
        r_overflow <= !((&w_top_bits) || !(|w_top_bits));
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.out_valid    = (r_state == ST_DONE);
  assign bus.busy         = (r_state == ST_BUSY);
  assign bus.out_result   = r_result;
  assign bus.out_overflow = r_overflow;
endmodule
